// File: rtl/esp_frame_tx_if.sv
// Bundle of the ESP PIO inputs and the UART/status outputs of esp_frame_tx.
interface esp_frame_tx_if;
    logic [7:0]  esp_data;
    logic [1:0]  esp_type;
    logic        esp_txd;
    logic        busy;
    logic [15:0] frame_count;

    // Software/PIO side: drives the payload, observes line and status
    modport master (
        output esp_data,
        output esp_type,
        input  esp_txd,
        input  busy,
        input  frame_count
    );

    // Framer side
    modport slave (
        input  esp_data,
        input  esp_type,
        output esp_txd,
        output busy,
        output frame_count
    );
endinterface

// File: rtl/esp_frame_tx.sv
// Watches the {type,data} PIO pair and sends each new value as a 4-byte
// UART 8N1 frame: START, TYPE, DATA, CHK. Updates arriving mid-frame coalesce.
module esp_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  START_BYTE   = 8'hA5
) (
    input  logic           clk_clk,
    input  logic           reset_reset,
    esp_frame_tx_if.slave  bus
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [TMR_W-1:0]  r_tmr;
    logic [2:0]        r_bit_idx;
    logic [1:0]        r_byte_idx;
    logic [9:0]        r_in_q;
    logic [9:0]        r_sent_q;
    logic              r_txd;
    logic              r_busy;
    logic [15:0]       r_frame_count;

    state_t            w_state_nxt;
    logic [TMR_W-1:0]  w_tmr_nxt;
    logic [2:0]        w_bit_idx_nxt;
    logic [1:0]        w_byte_idx_nxt;
    logic [9:0]        w_sent_q_nxt;
    logic              w_txd_nxt;
    logic              w_busy_nxt;
    logic [15:0]       w_frame_count_nxt;
    logic              w_tmr_done;
    logic [2:0]        w_bit_inc;
    logic [7:0]        w_chk;
    logic [7:0]        w_byte_cur;

    assign w_tmr_done = (r_tmr == TMR_LAST);
    assign w_bit_inc  = r_bit_idx + 3'd1;
    assign w_chk      = START_BYTE ^ {6'b0, r_sent_q[9:8]} ^ r_sent_q[7:0];

    // Byte currently on the line, built from the snapshot latched at the trigger
    always_comb begin
        w_byte_cur = w_chk;
        unique case (r_byte_idx)
            2'd0:    w_byte_cur = START_BYTE;
            2'd1:    w_byte_cur = {6'b0, r_sent_q[9:8]};
            2'd2:    w_byte_cur = r_sent_q[7:0];
            default: w_byte_cur = w_chk;
        endcase
    end

    // Next-state, bit timing and registered-output values
    always_comb begin
        w_state_nxt       = r_state;
        w_tmr_nxt         = w_tmr_done ? '0 : r_tmr + TMR_W'(1);
        w_bit_idx_nxt     = r_bit_idx;
        w_byte_idx_nxt    = r_byte_idx;
        w_sent_q_nxt      = r_sent_q;
        w_txd_nxt         = r_txd;
        w_busy_nxt        = r_busy;
        w_frame_count_nxt = r_frame_count;

        unique case (r_state)
            S_IDLE: begin
                w_tmr_nxt = '0;
                if (r_in_q != r_sent_q) begin
                    w_state_nxt    = S_START;
                    w_sent_q_nxt   = r_in_q;
                    w_byte_idx_nxt = 2'd0;
                    w_bit_idx_nxt  = 3'd0;
                    w_txd_nxt      = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_START: begin
                if (w_tmr_done) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_txd_nxt     = w_byte_cur[0];
                end
            end
            S_DATA: begin
                if (w_tmr_done) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_bit_idx_nxt = w_bit_inc;
                        w_txd_nxt     = w_byte_cur[w_bit_inc];
                    end
                end
            end
            S_STOP: begin
                if (w_tmr_done) begin
                    if (r_byte_idx == 2'd3) begin
                        w_state_nxt       = S_IDLE;
                        w_busy_nxt        = 1'b0;
                        w_frame_count_nxt = r_frame_count + 16'd1;
                    end else begin
                        w_state_nxt    = S_START;
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        w_txd_nxt      = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, input capture and output registers; reset aborts any frame
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_bit_idx     <= 3'd0;
            r_byte_idx    <= 2'd0;
            r_in_q        <= 10'd0;
            r_sent_q      <= 10'd0;
            r_txd         <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_tmr         <= w_tmr_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_byte_idx    <= w_byte_idx_nxt;
            r_in_q        <= {bus.esp_type, bus.esp_data};
            r_sent_q      <= w_sent_q_nxt;
            r_txd         <= w_txd_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_count <= w_frame_count_nxt;
        end
    end

    assign bus.esp_txd     = r_txd;
    assign bus.busy        = r_busy;
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_esp_frame_tx.sv
// Directed bench for esp_frame_tx with CLKS_PER_BIT=4 (one frame = 160 cycles).
module tb_esp_frame_tx;

    localparam int unsigned CPB = 4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   chg_off[3];
    logic [9:0] chg_val[3];
    int   nchg;

    esp_frame_tx_if bus ();

    esp_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .START_BYTE   (8'hA5)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decode one frame from its start bit; optionally change inputs at given offsets
    task automatic rx_frame(input string tag, input logic [1:0] e_type, input logic [7:0] e_data,
                            input logic [7:0] e_chk, input logic [15:0] e_cnt);
        int waited;
        int off;
        int target;
        logic [7:0] exp_b[4];
        logic [7:0] b;
        exp_b[0] = 8'hA5;
        exp_b[1] = {6'b0, e_type};
        exp_b[2] = e_data;
        exp_b[3] = e_chk;
        waited = 0;
        while (bus.esp_txd !== 1'b0 && waited < 2000) begin
            tick();
            waited++;
        end
        check({tag, "_start_seen"}, 32'(waited < 2000), 32'd1);
        check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        off = 0;
        for (int j = 0; j < 4; j++) begin
            for (int i = -1; i < 9; i++) begin
                target = j * 40 + (i + 1) * int'(CPB) + 2;
                while (off < target) begin
                    tick();
                    off++;
                    for (int k = 0; k < nchg; k++)
                        if (chg_off[k] == off) {bus.esp_type, bus.esp_data} = chg_val[k];
                end
                if (i == -1)
                    check($sformatf("%s_b%0d_start", tag, j), 32'(bus.esp_txd), 32'd0);
                else if (i == 8)
                    check($sformatf("%s_b%0d_stop", tag, j), 32'(bus.esp_txd), 32'd1);
                else
                    b[i] = bus.esp_txd;
            end
            check($sformatf("%s_byte%0d", tag, j), 32'(b), 32'(exp_b[j]));
        end
        while (off < 159) begin
            tick();
            off++;
        end
        check({tag, "_busy_last"}, 32'(bus.busy), 32'd1);
        tick();
        check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        check({tag, "_count"}, 32'(bus.frame_count), 32'(e_cnt));
        nchg = 0;
    endtask

    initial begin
        bit ok;
        int waited;
        tests_run    = 0;
        tests_failed = 0;
        nchg         = 0;
        rst          = 1'b1;
        bus.esp_data = 8'h00;
        bus.esp_type = 2'b00;
        tick();
        tick();
        check("reset_txd", 32'(bus.esp_txd), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_count", 32'(bus.frame_count), 32'd0);
        rst = 1'b0;

        // 1: zero inputs after reset are not a change
        ok = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (bus.esp_txd !== 1'b1 || bus.busy !== 1'b0 || bus.frame_count !== 16'd0) ok = 1'b0;
        end
        check("idle_200", 32'(ok), 32'd1);

        // 2: first frame and two-cycle latency
        bus.esp_type = 2'b01;
        bus.esp_data = 8'h3C;
        tick();
        check("lat_n1_txd", 32'(bus.esp_txd), 32'd1);
        tick();
        check("lat_n2_txd", 32'(bus.esp_txd), 32'd0);
        rx_frame("f1", 2'b01, 8'h3C, 8'h98, 16'd1);

        // 3: coalescing - only the last mid-frame value follows
        bus.esp_type = 2'b10;
        bus.esp_data = 8'h11;
        chg_off[0] = 50;  chg_val[0] = {2'b10, 8'h22};
        chg_off[1] = 90;  chg_val[1] = {2'b10, 8'h33};
        nchg = 2;
        rx_frame("f2", 2'b10, 8'h11, 8'hB6, 16'd2);
        tick();
        check("f3_back2back_txd", 32'(bus.esp_txd), 32'd0);
        check("f3_back2back_busy", 32'(bus.busy), 32'd1);
        rx_frame("f3", 2'b10, 8'h33, 8'h94, 16'd3);
        ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.esp_txd !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check("f3_no_extra", 32'(ok), 32'd1);

        // 4: change and revert mid-frame gives no second frame
        bus.esp_data = 8'h44;
        chg_off[0] = 60;  chg_val[0] = {2'b10, 8'h55};
        chg_off[1] = 100; chg_val[1] = {2'b10, 8'h44};
        nchg = 2;
        rx_frame("f4", 2'b10, 8'h44, 8'hE3, 16'd4);
        ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.esp_txd !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check("f4_no_extra", 32'(ok), 32'd1);
        check("f4_count_hold", 32'(bus.frame_count), 32'd4);

        // 5: reset during byte 2 aborts the frame
        bus.esp_type = 2'b11;
        bus.esp_data = 8'h5A;
        waited = 0;
        while (bus.esp_txd !== 1'b0 && waited < 2000) begin
            tick();
            waited++;
        end
        check("abort_start_seen", 32'(waited < 2000), 32'd1);
        for (int c = 0; c < 85; c++) tick();
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_txd", 32'(bus.esp_txd), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_count", 32'(bus.frame_count), 32'd0);
        bus.esp_type = 2'b00;
        bus.esp_data = 8'h00;
        tick();
        rst = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.esp_txd !== 1'b1 || bus.busy !== 1'b0 || bus.frame_count !== 16'd0) ok = 1'b0;
        end
        check("abort_quiet", 32'(ok), 32'd1);

        // 6: frame_count wraps from FFFF to 0
        force dut.r_frame_count = 16'hFFFF;
        tick();
        tick();
        release dut.r_frame_count;
        tick();
        check("wrap_preload", 32'(bus.frame_count), 32'h0000FFFF);
        bus.esp_type = 2'b01;
        bus.esp_data = 8'h00;
        rx_frame("f5", 2'b01, 8'h00, 8'hA4, 16'h0000);

        // Rewriting the same value never produces a frame
        bus.esp_type = 2'b01;
        bus.esp_data = 8'h00;
        ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.esp_txd !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check("same_value_quiet", 32'(ok), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
